// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage: result-select codes,
// load funct3 codes and FSM state encoding.
package writeback_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_COMMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational RV32 load alignment: picks the byte/half/word addressed by
// offset, sign- or zero-extends it, and flags misaligned or unknown loads.
module writeback_stage_load_extend
  import writeback_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Misaligned halves/words and reserved funct3 codes are reported, not trapped.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'b0, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = offset[0];
      end
      F3_LHU: begin
        data = {16'b0, half_sel};
        err  = offset[0];
      end
      F3_LW: begin
        data = word;
        err  = |offset;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the write-back value, waits for load data,
// and drives the register-file write port one cycle after the decision.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_reg_write,
  input  logic [AWIDTH-1:0] i_rd_addr,
  input  logic [1:0]        i_wb_sel,
  input  logic [2:0]        i_funct3,
  input  logic [DWIDTH-1:0] i_alu_result,
  input  logic [DWIDTH-1:0] i_pc,
  input  logic [DWIDTH-1:0] i_imm,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic              o_we,
  output logic [AWIDTH-1:0] o_addr_rd,
  output logic [DWIDTH-1:0] o_data_rd,
  output logic              o_load_err,
  output logic [CWIDTH-1:0] o_retired
);

  state_t state, state_next;

  logic              pend_reg_write;
  logic [AWIDTH-1:0] pend_rd;
  logic [1:0]        pend_offset;
  logic [2:0]        pend_funct3;
  logic              pend_err;

  logic              accept;
  logic              commit;
  logic              c_reg_write;
  logic [AWIDTH-1:0] c_rd;
  logic [DWIDTH-1:0] c_data;
  logic              c_err;

  logic [1:0]        ext_offset;
  logic [2:0]        ext_funct3;
  logic [DWIDTH-1:0] ext_data;
  logic              ext_err;

  assign o_ready = (state != ST_WAIT_MEM);
  assign accept  = i_valid & o_ready;

  // One extender serves both jobs: error check at accept, data extraction while waiting.
  assign ext_offset = (state == ST_WAIT_MEM) ? pend_offset : i_alu_result[1:0];
  assign ext_funct3 = (state == ST_WAIT_MEM) ? pend_funct3 : i_funct3;

  writeback_stage_load_extend u_load_extend (
    .word   (i_mem_rdata),
    .offset (ext_offset),
    .funct3 (ext_funct3),
    .data   (ext_data),
    .err    (ext_err)
  );

  always_comb begin
    state_next  = state;
    commit      = 1'b0;
    c_reg_write = i_reg_write;
    c_rd        = i_rd_addr;
    c_data      = '0;
    c_err       = 1'b0;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        state_next = ST_IDLE;
        if (i_valid) begin
          if (i_wb_sel == WB_MEM) begin
            state_next = ST_WAIT_MEM;
          end else begin
            state_next = ST_COMMIT;
            commit     = 1'b1;
            case (i_wb_sel)
              WB_ALU:  c_data = i_alu_result;
              WB_PC4:  c_data = i_pc + DWIDTH'(4);
              WB_IMM:  c_data = i_imm;
              default: c_data = '0;
            endcase
          end
        end
      end
      ST_WAIT_MEM: begin
        if (i_mem_rvalid) begin
          state_next  = ST_COMMIT;
          commit      = 1'b1;
          c_reg_write = pend_reg_write;
          c_rd        = pend_rd;
          c_data      = ext_data;
          c_err       = pend_err;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output registers are loaded on the edge entering COMMIT, so they are live exactly then.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state          <= ST_IDLE;
      o_we           <= 1'b0;
      o_load_err     <= 1'b0;
      o_addr_rd      <= '0;
      o_data_rd      <= '0;
      o_retired      <= '0;
      pend_reg_write <= 1'b0;
      pend_rd        <= '0;
      pend_offset    <= '0;
      pend_funct3    <= '0;
      pend_err       <= 1'b0;
    end else begin
      state      <= state_next;
      o_we       <= commit & c_reg_write & (c_rd != '0) & ~c_err;
      o_load_err <= commit & c_err;
      if (commit) begin
        o_addr_rd <= c_rd;
        o_data_rd <= c_data;
        o_retired <= o_retired + CWIDTH'(1);
      end
      if (accept && (i_wb_sel == WB_MEM)) begin
        pend_reg_write <= i_reg_write;
        pend_rd        <= i_rd_addr;
        pend_offset    <= i_alu_result[1:0];
        pend_funct3    <= i_funct3;
        pend_err       <= ext_err;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: transaction-level model checked
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_writeback_stage;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [1:0]  i_wb_sel = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_imm = '0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_rvalid = 1'b0;
  logic        o_we;
  logic [4:0]  o_addr_rd;
  logic [31:0] o_data_rd;
  logic        o_load_err;
  logic [15:0] o_retired;

  int total = 0;
  int bad = 0;
  logic check_en = 1'b0;

  writeback_stage #(.AWIDTH(5), .DWIDTH(32), .CWIDTH(16)) dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_reg_write  (i_reg_write),
    .i_rd_addr    (i_rd_addr),
    .i_wb_sel     (i_wb_sel),
    .i_funct3     (i_funct3),
    .i_alu_result (i_alu_result),
    .i_pc         (i_pc),
    .i_imm        (i_imm),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_rvalid (i_mem_rvalid),
    .o_we         (o_we),
    .o_addr_rd    (o_addr_rd),
    .o_data_rd    (o_data_rd),
    .o_load_err   (o_load_err),
    .o_retired    (o_retired)
  );

  always #5 r_clk = ~r_clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Load result from plain shift/mask arithmetic on the memory word.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = w >> (8 * off);
    h_sh = w >> (16 * off[1]);
    case (f3)
      3'd0: return 32'($signed(b_sh[7:0]));
      3'd4: return b_sh & 32'h0000_00ff;
      3'd1: return 32'($signed(h_sh[15:0]));
      3'd5: return h_sh & 32'h0000_ffff;
      default: return w;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == 3'd1 || f3 == 3'd5) && off[0]) || (f3 == 3'd2 && off != 2'd0) ||
           (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  logic        m_wait = 1'b0;
  logic        m_p_rw, m_p_err;
  logic [4:0]  m_p_rd;
  logic [1:0]  m_p_off;
  logic [2:0]  m_p_f3;
  logic        exp_we = 1'b0, exp_err = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  int unsigned m_retired = 0;
  logic        do_commit, c_rw, c_err;
  logic [4:0]  c_rd;
  logic [31:0] c_data;

  always @(posedge r_clk) begin
    if (r_rst) begin
      m_wait = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
      exp_addr = '0; exp_data = '0; m_retired = 0;
    end else begin
      do_commit = 1'b0; c_rw = 1'b0; c_err = 1'b0; c_rd = '0; c_data = '0;
      if (m_wait) begin
        if (i_mem_rvalid) begin
          do_commit = 1'b1; c_rw = m_p_rw; c_rd = m_p_rd; c_err = m_p_err;
          c_data = model_load(i_mem_rdata, m_p_off, m_p_f3);
          m_wait = 1'b0;
        end
      end else if (i_valid) begin
        if (i_wb_sel == 2'd1) begin
          m_wait = 1'b1; m_p_rw = i_reg_write; m_p_rd = i_rd_addr;
          m_p_off = i_alu_result[1:0]; m_p_f3 = i_funct3;
          m_p_err = model_illegal(i_funct3, i_alu_result[1:0]);
        end else begin
          do_commit = 1'b1; c_rw = i_reg_write; c_rd = i_rd_addr;
          c_data = (i_wb_sel == 2'd0) ? i_alu_result : (i_wb_sel == 2'd2) ? i_pc + 32'd4 : i_imm;
        end
      end
      exp_we  = do_commit && c_rw && (c_rd != 5'd0) && !c_err;
      exp_err = do_commit && c_err;
      if (do_commit) begin
        exp_addr = c_rd; exp_data = c_data; m_retired++;
      end
    end
    #1;
    if (check_en) begin
      check_output("cyc_we", o_we, exp_we);
      check_output("cyc_load_err", o_load_err, exp_err);
      check_output("cyc_ready", o_ready, !m_wait);
      check_output("cyc_retired", o_retired, m_retired[15:0]);
      if (exp_we) begin
        check_output("cyc_addr", o_addr_rd, exp_addr);
        check_output("cyc_data", o_data_rd, exp_data);
      end
    end
  end

  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge r_clk) if (o_we) regs[o_addr_rd] <= o_data_rd;

  task automatic apply_stimulus(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [31:0] imm);
    @(negedge r_clk);
    i_valid = 1'b1; i_mem_rvalid = 1'b0;
    i_reg_write = rw; i_rd_addr = rd; i_wb_sel = sel; i_funct3 = f3;
    i_alu_result = alu; i_pc = pc; i_imm = imm;
    @(posedge r_clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge r_clk);
      i_valid = 1'b0; i_mem_rvalid = 1'b0;
      @(posedge r_clk); #2;
    end
  endtask

  task automatic mem_resp(input logic [31:0] d);
    @(negedge r_clk);
    i_valid = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = d;
    @(posedge r_clk); #2;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int gap);
    apply_stimulus(1'b1, rd, 2'd1, f3, addr, 32'h0, 32'h0);
    idle(gap);
    mem_resp(rdata);
  endtask

  int we_cnt;

  initial begin
    // Reset held two cycles
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b0;
    #1;
    check_output("rst_we", o_we, 1'b0);
    check_output("rst_retired", o_retired, 16'd0);
    check_output("rst_ready", o_ready, 1'b1);
    check_en = 1'b1;

    // ALU write to x5
    apply_stimulus(1'b1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    check_output("alu_we", o_we, 1'b1);
    check_output("alu_addr", o_addr_rd, 5'd5);
    check_output("alu_data", o_data_rd, 32'h1234);
    idle(1);
    check_output("regfile_rs1_x5", regs[5], 32'h1234);

    // LB / LBU at offset 3 with data two cycles later
    apply_stimulus(1'b1, 5'd7, 2'd1, 3'd0, 32'h0000_1003, 32'h0, 32'h0);
    check_output("lb_wait_ready", o_ready, 1'b0);
    idle(1);
    check_output("lb_wait_ready2", o_ready, 1'b0);
    mem_resp(32'h80FF_0000);
    check_output("lb_we", o_we, 1'b1);
    check_output("lb_data", o_data_rd, 32'hFFFF_FF80);
    do_load(5'd8, 3'd4, 32'h0000_1003, 32'h80FF_0000, 1);
    check_output("lbu_data", o_data_rd, 32'h0000_0080);

    // Misaligned LW, then aligned LH
    do_load(5'd9, 3'd2, 32'h0000_0102, 32'h1111_2222, 1);
    check_output("lw_mis_err", o_load_err, 1'b1);
    check_output("lw_mis_we", o_we, 1'b0);
    check_output("lw_mis_retired", o_retired, 16'd4);
    idle(1);
    check_output("err_pulse_end", o_load_err, 1'b0);
    do_load(5'd10, 3'd1, 32'h0000_0002, 32'h8001_0000, 0);
    check_output("lh_data", o_data_rd, 32'hFFFF_8001);
    check_output("lh_retired", o_retired, 16'd5);

    // 20 back-to-back ALU ops, rd=i data=i
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 5'(i), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
      if (o_we) we_cnt++;
    end
    check_output("b2b_we_count", we_cnt, 19);
    check_output("b2b_retired", o_retired, 16'd25);
    do_load(5'd20, 3'd2, 32'h0000_0008, 32'h1234_5678, 0);
    idle(1);
    check_output("x0_reads_zero", regs[0], 32'h0);
    check_output("regfile_x19", regs[19], 32'd19);
    check_output("regfile_x20", regs[20], 32'h1234_5678);

    // Further load shapes, covered by the per-cycle model
    do_load(5'd11, 3'd0, 32'h0000_0001, 32'h0000_7F00, 0);
    do_load(5'd12, 3'd5, 32'h0000_0000, 32'h1234_F00D, 2);
    do_load(5'd13, 3'd1, 32'h0000_0000, 32'h0000_8000, 0);
    do_load(5'd14, 3'd2, 32'h0000_0000, 32'hDEAD_BEEF, 1);
    do_load(5'd15, 3'd1, 32'h0000_0001, 32'h0000_8000, 0);
    do_load(5'd16, 3'd3, 32'h0000_0000, 32'h0000_0001, 0);
    do_load(5'd17, 3'd5, 32'h0000_0002, 32'hBEEF_0000, 0);
    check_output("lhu_hi_data", o_data_rd, 32'h0000_BEEF);
    apply_stimulus(1'b0, 5'd18, 2'd0, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
    check_output("nowrite_we", o_we, 1'b0);
    apply_stimulus(1'b1, 5'd21, 2'd3, 3'd0, 32'h0, 32'h0, 32'hABCD_E000);
    check_output("imm_data", o_data_rd, 32'hABCD_E000);
    mem_resp(32'hFFFF_FFFF);
    idle(1);

    // Reset while waiting for load data
    apply_stimulus(1'b1, 5'd3, 2'd1, 3'd2, 32'h0000_0040, 32'h0, 32'h0);
    idle(1);
    @(negedge r_clk);
    r_rst = 1'b1; i_valid = 1'b0;
    @(posedge r_clk); #2;
    @(negedge r_clk);
    r_rst = 1'b0;
    #1;
    check_output("midrst_we", o_we, 1'b0);
    check_output("midrst_retired", o_retired, 16'd0);
    check_output("midrst_ready", o_ready, 1'b1);
    mem_resp(32'h0000_0055);
    check_output("stale_rvalid_we", o_we, 1'b0);
    apply_stimulus(1'b1, 5'd9, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    check_output("pc4_wrap_we", o_we, 1'b1);
    check_output("pc4_wrap_data", o_data_rd, 32'h0);
    check_output("pc4_retired", o_retired, 16'd1);
    idle(2);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
